// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, redirect flush, MDU freeze,
// operand forwarding selects and saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int MDU_LAT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwr,
  input  logic        ex_dmld,
  input  logic [4:0]  mem_rd,
  input  logic        mem_regwr,
  input  logic        ex_redirect,
  input  logic        ex_mdu_start,
  input  logic        clr_cnt,
  output logic [1:0]  rfd1sel,
  output logic [1:0]  rfd2sel,
  output logic        stall_if,
  output logic        bubble_ex,
  output logic        flush,
  output logic        freeze,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic        dbg_state
);

  typedef enum logic {RUN = 1'b0, MDU = 1'b1} state_t;

  localparam logic [4:0] MDU_LOAD = 5'(MDU_LAT - 1);

  state_t     state, state_nxt;
  logic [4:0] mdu_cnt, mdu_cnt_nxt;
  logic       load_use;
  logic       ex_fwd_ok, mem_fwd_ok;

  assign dbg_state = state;

  assign load_use = ex_dmld & ex_regwr & (ex_rd != 5'd0) &
                    ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));

  // A load in EX has no result yet, so it is never a forwarding source.
  assign ex_fwd_ok  = ex_regwr & ~ex_dmld & (ex_rd != 5'd0);
  assign mem_fwd_ok = mem_regwr & (mem_rd != 5'd0);

  always_comb begin
    rfd1sel = 2'b00;
    if (ex_fwd_ok && (ex_rd == id_rs))        rfd1sel = 2'b01;
    else if (mem_fwd_ok && (mem_rd == id_rs)) rfd1sel = 2'b10;
  end

  always_comb begin
    rfd2sel = 2'b00;
    if (ex_fwd_ok && (ex_rd == id_rt))        rfd2sel = 2'b01;
    else if (mem_fwd_ok && (mem_rd == id_rt)) rfd2sel = 2'b10;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      mdu_cnt <= 5'd0;
    end else begin
      state   <= state_nxt;
      mdu_cnt <= mdu_cnt_nxt;
    end
  end

  // Freeze outranks flush, which outranks the load-use stall.
  always_comb begin
    state_nxt   = state;
    mdu_cnt_nxt = mdu_cnt;
    freeze      = 1'b0;
    flush       = 1'b0;
    stall_if    = 1'b0;
    bubble_ex   = 1'b0;
    case (state)
      RUN: begin
        flush     = ex_redirect;
        stall_if  = load_use & ~ex_redirect;
        bubble_ex = load_use & ~ex_redirect;
        if (ex_mdu_start) begin
          state_nxt   = MDU;
          mdu_cnt_nxt = MDU_LOAD;
        end
      end
      MDU: begin
        freeze = 1'b1;
        if (mdu_cnt == 5'd0) state_nxt = RUN;
        else                 mdu_cnt_nxt = mdu_cnt - 5'd1;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else if (clr_cnt) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if ((stall_if | freeze) && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (flush && (flush_cnt != 16'hFFFF))               flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus random traffic,
// checked against a cycle-level reference model of the hazard rules.
module tb_hazard_ctrl;

  localparam int MDU_LAT = 8;

  typedef struct packed {
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic [4:0] ex_rd;
    logic       ex_regwr;
    logic       ex_dmld;
    logic [4:0] mem_rd;
    logic       mem_regwr;
    logic       ex_redirect;
    logic       ex_mdu_start;
    logic       clr_cnt;
    logic       rst_n;
  } stim_t;

  // clock / reset and DUT signals
  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_rd, mem_rd;
  logic        id_use_rs, id_use_rt, ex_regwr, ex_dmld, mem_regwr;
  logic        ex_redirect, ex_mdu_start, clr_cnt;
  logic [1:0]  rfd1sel, rfd2sel;
  logic        stall_if, bubble_ex, flush, freeze, dbg_state;
  logic [15:0] stall_cnt, flush_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  hazard_ctrl #(.MDU_LAT(MDU_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_rd(ex_rd), .ex_regwr(ex_regwr), .ex_dmld(ex_dmld),
    .mem_rd(mem_rd), .mem_regwr(mem_regwr),
    .ex_redirect(ex_redirect), .ex_mdu_start(ex_mdu_start), .clr_cnt(clr_cnt),
    .rfd1sel(rfd1sel), .rfd2sel(rfd2sel), .stall_if(stall_if), .bubble_ex(bubble_ex),
    .flush(flush), .freeze(freeze), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .dbg_state(dbg_state)
  );

  // scoreboard state
  logic [40:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;

  // reference model state
  int m_busy = 0;
  int m_scnt = 0;
  int m_fcnt = 0;

  function automatic logic [1:0] ref_fwd(input stim_t s, input logic [4:0] src);
    if (s.ex_regwr && !s.ex_dmld && s.ex_rd != 0 && s.ex_rd == src) return 2'b01;
    if (s.mem_regwr && s.mem_rd != 0 && s.mem_rd == src)           return 2'b10;
    return 2'b00;
  endfunction

  // {rfd1sel, rfd2sel, stall_if, bubble_ex, flush, freeze, dbg_state, stall_cnt, flush_cnt}
  function automatic logic [40:0] model_out(input stim_t s);
    logic frz, haz, fl, st;
    frz = (m_busy > 0);
    haz = s.ex_dmld && s.ex_regwr && s.ex_rd != 0 &&
          ((s.id_use_rs && s.id_rs == s.ex_rd) || (s.id_use_rt && s.id_rt == s.ex_rd));
    fl  = !frz && s.ex_redirect;
    st  = !frz && haz && !s.ex_redirect;
    return {ref_fwd(s, s.id_rs), ref_fwd(s, s.id_rt), st, st, fl, frz, frz,
            16'(m_scnt), 16'(m_fcnt)};
  endfunction

  task automatic model_reset();
    m_busy = 0;
    m_scnt = 0;
    m_fcnt = 0;
  endtask

  task automatic model_edge(input stim_t s, input logic [40:0] e);
    if (!s.rst_n) begin
      model_reset();
    end else begin
      if (s.clr_cnt) begin
        m_scnt = 0;
        m_fcnt = 0;
      end else begin
        if (e[36] || e[33]) m_scnt = (m_scnt < 65535) ? m_scnt + 1 : 65535;
        if (e[34])          m_fcnt = (m_fcnt < 65535) ? m_fcnt + 1 : 65535;
      end
      if (m_busy > 0)          m_busy = m_busy - 1;
      else if (s.ex_mdu_start) m_busy = MDU_LAT;
    end
  endtask

  // driver: called one time unit after a rising edge
  task automatic drive_cycle(input stim_t s);
    logic [40:0] e;
    id_rs = s.id_rs;   id_rt = s.id_rt;
    id_use_rs = s.id_use_rs; id_use_rt = s.id_use_rt;
    ex_rd = s.ex_rd;   ex_regwr = s.ex_regwr; ex_dmld = s.ex_dmld;
    mem_rd = s.mem_rd; mem_regwr = s.mem_regwr;
    ex_redirect = s.ex_redirect; ex_mdu_start = s.ex_mdu_start;
    clr_cnt = s.clr_cnt; rst_n = s.rst_n;
    if (!s.rst_n) model_reset();
    e = model_out(s);
    exp_q.push_back(e);
    @(posedge clk);
    model_edge(s, e);
    #1;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic stim_t load_use_stim();
    stim_t s;
    s = idle();
    s.ex_dmld = 1'b1; s.ex_regwr = 1'b1; s.ex_rd = 5'd5;
    s.id_rs = 5'd5;   s.id_use_rs = 1'b1;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.id_rs        = 5'($urandom_range(0, 3));
    s.id_rt        = 5'($urandom_range(0, 3));
    s.id_use_rs    = 1'($urandom_range(0, 1));
    s.id_use_rt    = 1'($urandom_range(0, 1));
    s.ex_rd        = 5'($urandom_range(0, 3));
    s.ex_regwr     = 1'($urandom_range(0, 1));
    s.ex_dmld      = 1'($urandom_range(0, 1));
    s.mem_rd       = 5'($urandom_range(0, 3));
    s.mem_regwr    = 1'($urandom_range(0, 1));
    s.ex_redirect  = ($urandom_range(0, 5) == 0);
    s.ex_mdu_start = ($urandom_range(0, 15) == 0);
    s.clr_cnt      = ($urandom_range(0, 39) == 0);
    s.rst_n        = ($urandom_range(0, 199) != 0);
    return s;
  endfunction

  // monitor: every cycle presents one output vector, sampled on the falling edge
  always @(negedge clk) begin
    logic [40:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {rfd1sel, rfd2sel, stall_if, bubble_ex, flush, freeze, dbg_state, stall_cnt, flush_cnt};
      n_vec++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs t=%0t act rfd1=%b rfd2=%b st=%b bub=%b fl=%b frz=%b dbg=%b scnt=%h fcnt=%h exp rfd1=%b rfd2=%b st=%b bub=%b fl=%b frz=%b dbg=%b scnt=%h fcnt=%h",
                 $time, a[40:39], a[38:37], a[36], a[35], a[34], a[33], a[32], a[31:16], a[15:0],
                 e[40:39], e[38:37], e[36], e[35], e[34], e[33], e[32], e[31:16], e[15:0]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    s = '0;
    rst_n = 1'b0;
    id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0;
    ex_rd = '0; ex_regwr = 0; ex_dmld = 0; mem_rd = '0; mem_regwr = 0;
    ex_redirect = 0; ex_mdu_start = 0; clr_cnt = 0;
    @(posedge clk);
    #1;

    // reset state
    for (int i = 0; i < 3; i++) drive_cycle(s);

    // load-use stall, then the load forwarded from MEM
    drive_cycle(idle());
    drive_cycle(load_use_stim());
    s = idle(); s.mem_rd = 5'd5; s.mem_regwr = 1'b1; s.id_rs = 5'd5; s.id_use_rs = 1'b1;
    drive_cycle(s);

    // EX beats MEM; register 0 never forwarded
    s = idle(); s.ex_rd = 5'd7; s.mem_rd = 5'd7; s.ex_regwr = 1; s.mem_regwr = 1; s.id_rt = 5'd7;
    drive_cycle(s);
    s = idle(); s.ex_rd = 5'd0; s.id_rs = 5'd0; s.ex_regwr = 1; s.mem_rd = 5'd0; s.mem_regwr = 1;
    drive_cycle(s);

    // MDU freeze with redirect and restart attempts ignored
    drive_cycle(idle());
    s = idle(); s.ex_mdu_start = 1'b1;
    drive_cycle(s);
    for (int i = 0; i < 11; i++) begin
      s = (i % 2 == 1) ? load_use_stim() : idle();
      s.ex_redirect  = (i == 2 || i == 4 || i == 7);
      s.ex_mdu_start = (i == 5);
      drive_cycle(s);
    end

    // redirect beats load-use stall; redirect with MDU start
    s = load_use_stim(); s.ex_redirect = 1'b1;
    drive_cycle(s);
    s.ex_mdu_start = 1'b1;
    drive_cycle(s);
    for (int i = 0; i < 9; i++) drive_cycle(idle());

    // reset in the 4th MDU cycle
    s = idle(); s.ex_mdu_start = 1'b1;
    drive_cycle(s);
    for (int i = 0; i < 3; i++) drive_cycle(idle());
    s = idle(); s.rst_n = 1'b0; s.ex_redirect = 1'b1;
    drive_cycle(s);
    s.ex_redirect = 1'b0;
    drive_cycle(s);
    for (int i = 0; i < 3; i++) drive_cycle(load_use_stim());

    // random traffic
    for (int i = 0; i < 2000; i++) drive_cycle(rand_stim());

    // stall counter saturation and clear
    s = idle(); s.clr_cnt = 1'b1;
    drive_cycle(s);
    for (int i = 0; i < 65540; i++) drive_cycle(load_use_stim());
    s = load_use_stim(); s.clr_cnt = 1'b1;
    drive_cycle(s);
    for (int i = 0; i < 3; i++) drive_cycle(load_use_stim());

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
